// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
//   div_state_e : controller states (IDLE, RUN, DONE)
//   DIV_WIDTH   : default operand/result width
//   CNT_W       : iteration counter width for the default width
//   cnt_w()     : iteration counter width for any width, clog2(w+1)
//   DBZ_QUO     : divide-by-zero quotient (all ones) at the default width
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int unsigned DIV_WIDTH = 8;

  // Counter must hold the value WIDTH itself, hence the +1.
  function automatic int unsigned cnt_w(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  localparam int unsigned CNT_W = $clog2(DIV_WIDTH + 1);

  localparam logic [DIV_WIDTH-1:0] DBZ_QUO = '1;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
//   prem     in  WIDTH  partial remainder before the shift
//   dvd_msb  in  1      dividend bit shifted into the partial remainder
//   divisor  in  WIDTH  divisor magnitude
//   prem_nxt out WIDTH  partial remainder after the conditional subtract
//   qbit     out 1      quotient bit produced by this step
module div_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] prem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] prem_nxt,
  output logic             qbit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] dsr_ext;

  // Compare at WIDTH+1 bits so the bit shifted out of prem is not lost.
  always_comb begin
    shifted  = {prem, dvd_msb};
    dsr_ext  = {1'b0, divisor};
    qbit     = (shifted >= dsr_ext);
    prem_nxt = qbit ? WIDTH'(shifted - dsr_ext) : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, start/done handshake.
// Optional macro DIV_SIGNED_EN adds signed_op for two's-complement truncating division.
//   clk, rst_n  : clock, async active-low reset
//   start       : request, sampled only when not busy
//   dividend    : numerator, captured with start
//   divisor     : denominator, captured with start
//   signed_op   : signed request (DIV_SIGNED_EN builds only)
//   busy        : high while iterating
//   done        : one-cycle pulse, results valid
//   quo, rem    : quotient/remainder, held until next completion
//   div_by_zero : captured divisor was zero, held with results
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             div_by_zero
);

  localparam int unsigned CW = cnt_w(WIDTH);

  div_state_e       state, state_nxt;
  logic [WIDTH-1:0] prem, dvd, dsr;
  logic [CW-1:0]    cnt;
  logic             neg_q, neg_r;

  logic             accept_c, dbz_c, last_c;
  logic             a_neg_c, b_neg_c;
  logic [WIDTH-1:0] a_mag_c, b_mag_c;
  logic [WIDTH-1:0] step_prem;
  logic             step_q;
  logic [WIDTH-1:0] q_c;

  // Operand magnitudes and sign capture.
`ifdef DIV_SIGNED_EN
  always_comb begin
    a_neg_c = signed_op & dividend[WIDTH-1];
    b_neg_c = signed_op & divisor[WIDTH-1];
    a_mag_c = a_neg_c ? -dividend : dividend;
    b_mag_c = b_neg_c ? -divisor  : divisor;
  end
`else
  always_comb begin
    a_neg_c = 1'b0;
    b_neg_c = 1'b0;
    a_mag_c = dividend;
    b_mag_c = divisor;
  end
`endif

  always_comb begin
    accept_c = start && (state != RUN);
    dbz_c    = (divisor == '0);
    last_c   = (cnt == CW'(1));
    q_c      = {dvd[WIDTH-2:0], step_q};
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .prem     (prem),
    .dvd_msb  (dvd[WIDTH-1]),
    .divisor  (dsr),
    .prem_nxt (step_prem),
    .qbit     (step_q)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start)              state_nxt = dbz_c ? DONE : RUN;
        else if (state == DONE) state_nxt = IDLE;
      end
      RUN:     if (last_c) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt == RUN);
      done <= (state_nxt == DONE);
    end
  end

  // Datapath: operand capture, iteration, and result load on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prem        <= '0;
      dvd         <= '0;
      dsr         <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      quo         <= '0;
      rem         <= '0;
      div_by_zero <= 1'b0;
    end else if (accept_c) begin
      prem  <= '0;
      dvd   <= a_mag_c;
      dsr   <= b_mag_c;
      cnt   <= CW'(WIDTH);
      neg_q <= a_neg_c ^ b_neg_c;
      neg_r <= a_neg_c;
      if (dbz_c) begin
        // Raw dividend is returned even for signed requests.
        quo         <= '1;
        rem         <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (state == RUN) begin
      prem <= step_prem;
      dvd  <= q_c;
      cnt  <= cnt - CW'(1);
      if (last_c) begin
        quo         <= neg_q ? -q_c : q_c;
        rem         <= neg_r ? -step_prem : step_prem;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=8): directed scenarios plus
// randomized operations against an arithmetic reference model.
// Build with DIV_SIGNED_EN to also exercise signed division.
module tb_seq_divider;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend, divisor;
`ifdef DIV_SIGNED_EN
  logic         signed_op;
`endif
  logic         busy, done, div_by_zero;
  logic [W-1:0] quo, rem;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef DIV_SIGNED_EN
    .signed_op   (signed_op),
`endif
    .busy        (busy),
    .done        (done),
    .quo         (quo),
    .rem         (rem),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division with truncation toward zero.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
    int sa, sb;
    z = (b == 0);
    if (z) begin
      q = '1;
      r = a;
    end else if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      q  = W'(sa / sb);
      r  = W'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Called at a negedge; start is sampled at the following posedge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
`ifdef DIV_SIGNED_EN
    signed_op = s;
`else
    if (s) $display("note: signed request ignored in unsigned build");
`endif
    @(negedge clk);
    start = 1'b0;
  endtask

  // lat = number of posedges from the start edge to the edge that samples done.
  task automatic wait_done(output int lat, output int bc);
    lat = 1;
    bc  = 0;
    while (!done && lat < 40) begin
      if (busy) bc++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s);
    int lat, bc;
    logic [W-1:0] eq, er;
    logic ez;
    launch(a, b, s);
    wait_done(lat, bc);
    ref_div(a, b, s, eq, er, ez);
    chk({tag, ".done"}, 32'(done), 32'(1));
    chk({tag, ".lat"},  32'(lat),  ez ? 32'(1) : 32'(W + 1));
    chk({tag, ".busy"}, 32'(bc),   ez ? 32'(0) : 32'(W));
    chk({tag, ".quo"},  32'(quo),  32'(eq));
    chk({tag, ".rem"},  32'(rem),  32'(er));
    chk({tag, ".dbz"},  32'(div_by_zero), 32'(ez));
  endtask

  initial begin
    int lat, bc, pulses;
    logic [W-1:0] ra, rb;
    logic rs;

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
`ifdef DIV_SIGNED_EN
    signed_op = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst.busy", 32'(busy), 32'(0));
    chk("rst.done", 32'(done), 32'(0));
    chk("rst.quo",  32'(quo),  32'(0));
    chk("rst.rem",  32'(rem),  32'(0));
    chk("rst.dbz",  32'(div_by_zero), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    check_op("u200_7", 8'd200, 8'd7, 1'b0);
    @(negedge clk);
    chk("pulse.done", 32'(done), 32'(0));
    chk("hold.quo",   32'(quo),  32'(28));

    check_op("u5_0", 8'd5, 8'd0, 1'b0);
    @(negedge clk);

    // Back-to-back: second start is sampled in the DONE cycle.
    check_op("b2b1", 8'd255, 8'd1,   1'b0);
    check_op("b2b2", 8'd255, 8'd255, 1'b0);
    @(negedge clk);

    // Start while busy must be ignored.
    launch(8'd100, 8'd3, 1'b0);
    @(negedge clk);
    start = 1'b1; dividend = 8'd9; divisor = 8'd2;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc);
    chk("ign.lat", 32'(lat + 2), 32'(W + 1));
    chk("ign.quo", 32'(quo), 32'(33));
    chk("ign.rem", 32'(rem), 32'(1));
    @(negedge clk);
    pulses = 0;
    repeat (12) begin
      if (done) pulses++;
      @(negedge clk);
    end
    chk("ign.extra_done", 32'(pulses), 32'(0));

    // Reset mid-run discards the operation.
    launch(8'd200, 8'd7, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst.busy", 32'(busy), 32'(0));
    chk("mrst.done", 32'(done), 32'(0));
    chk("mrst.quo",  32'(quo),  32'(0));
    chk("mrst.rem",  32'(rem),  32'(0));
    chk("mrst.dbz",  32'(div_by_zero), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (12) begin
      if (done || busy) pulses++;
      @(negedge clk);
    end
    chk("mrst.quiet", 32'(pulses), 32'(0));
    check_op("u9_2", 8'd9, 8'd2, 1'b0);
    @(negedge clk);

`ifdef DIV_SIGNED_EN
    check_op("s-7_2",    8'hF9, 8'h02, 1'b1);
    check_op("s7_-2",    8'h07, 8'hFE, 1'b1);
    check_op("s-128_-1", 8'h80, 8'hFF, 1'b1);
    check_op("s-5_0",    8'hFB, 8'h00, 1'b1);
    @(negedge clk);
`endif

    for (int i = 0; i < 60; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
`ifdef DIV_SIGNED_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      check_op($sformatf("rnd%0d", i), ra, rb, rs);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Parametrised multi-cycle restoring divider for the mini processor's arithmetic unit. It computes quotient and remainder of two WIDTH-bit operands at one quotient bit per clock, behind a start/done handshake. It detects divide-by-zero, and can optionally be built with signed (truncating) division. It replaces the single-event, fixed 8-bit divide path with a clocked, resettable, back-to-back-capable unit.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when busy=0
- dividend  in  WIDTH  numerator, captured with start
- divisor  in  WIDTH  denominator, captured with start
- signed_op  in  1  signed request (present only with DIV_SIGNED_EN)
- busy  out  1  high while iterating
- done  out  1  one-cycle pulse, results valid
- quo  out  WIDTH  quotient, held until next completion
- rem  out  WIDTH  remainder, held until next completion
- div_by_zero  out  1  set with done when captured divisor was 0; held with results

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1: latch operands, clear partial remainder, load counter = WIDTH.
  - Divisor ≠ 0: go to RUN.
  - Divisor = 0: go to DONE with quo = all ones, rem = dividend, div_by_zero = 1.
- RUN, each cycle: shift {prem, dvd} left by 1. If prem ≥ divisor (compared at WIDTH+1 bits so the shifted-out MSB is kept), subtract divisor and set the new quotient LSB to 1, else set it to 0. Decrement counter. At count 1, go to DONE and load quo/rem.
- DONE: done = 1 for exactly one cycle. Next state is RUN/DONE if start=1, else IDLE.
- start while busy=1 is ignored; operands are not re-sampled.
- quo, rem and div_by_zero change only on entry to DONE. They hold their values otherwise.
- Async reset at any point, including mid-RUN: state goes to IDLE, any in-flight operation is discarded, no done is issued.

## Timing
- Reset values: busy=0, done=0, quo=0, rem=0, div_by_zero=0.
- Start accepted at edge N:
  - Normal case: busy is high from N+1 to N+WIDTH; done and results appear at N+WIDTH+1.
  - Divide-by-zero: done appears at N+1 and busy stays 0.
- Back-to-back operation: a start sampled in the DONE cycle is accepted, giving one result every WIDTH+1 cycles.
- No combinational path from inputs to outputs.

## Configuration
- DIV_SIGNED_EN defined:
  - signed_op port exists. With signed_op=1, operands are two's complement.
  - Magnitudes are divided. The quotient is negated when the operand signs differ; the remainder takes the dividend's sign (truncation toward zero).
  - Sign fix-up is applied on entry to DONE, with no added latency.
  - -2^(WIDTH-1) / -1 gives quo = -2^(WIDTH-1), rem = 0 (wraps, no flag).
  - Divide-by-zero returns quo = all ones, rem = dividend (raw).
- DIV_SIGNED_EN undefined: there is no signed_op port, and all operations are unsigned.

## Structure
- Package div_pkg holds:
  - state enum typedef (IDLE, RUN, DONE)
  - counter width constant, clog2(WIDTH+1)
  - divide-by-zero quotient constant (all ones)
- Sub-module div_step: one combinational restoring step.
  - Inputs: prem, dvd MSB, divisor.
  - Outputs: next prem and quotient bit.
  - Instantiated once and reused each cycle.

## Test plan
All scenarios use WIDTH=8.
- 200 / 7 → quo=28, rem=4, div_by_zero=0. done exactly 9 cycles after the start edge; busy high for 8 cycles.
- 5 / 0 → quo=0xFF, rem=5, div_by_zero=1, done 1 cycle after start, busy never high.
- 255/1 then 255/255 back-to-back (second start in the DONE cycle) → 255 r0, then 1 r0, done pulses 9 cycles apart.
- Start 100/3, then a second start 9/2 at cycle 3 while busy → second start ignored; result 33 r1 only.
- Start 200/7, assert rst_n=0 at cycle 4 → all outputs 0, no done pulse; a following 9/2 gives 4 r1.
- DIV_SIGNED_EN cases, all with signed_op=1:
  - -7/2 → quo=0xFD, rem=0xFF
  - 7/-2 → quo=0xFD, rem=1
  - -128/-1 → quo=0x80, rem=0
